// File: rtl/vga_sync_if.sv
// Beam-position and pixel-output bundle between the VGA timing generator
// (master) and the pixel generator / pad logic (slave).
interface vga_sync_if;
    logic       en;
    logic [5:0] rgb_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic [7:0] uo_vga;

    modport master (
        input  en, rgb_in,
        output hpos, vpos, active, line_start, frame_start, uo_vga
    );

    modport slave (
        output en, rgb_in,
        input  hpos, vpos, active, line_start, frame_start, uo_vga
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA pixel/line counters plus the registered TinyVGA PMOD output byte;
// colour is masked to zero outside the visible area.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master bus
);

    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [7:0]  UO_RESET   = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

    logic [9:0]  h;
    logic [9:0]  v;
    logic [7:0]  uo;
    logic [10:0] h_x;
    logic [10:0] v_x;
    logic        active;
    logic        hs_i;
    logic        vs_i;
    logic        hs_pin;
    logic        vs_pin;
    logic [5:0]  rgb_m;

    assign h_x    = {1'b0, h};
    assign v_x    = {1'b0, v};
    assign active = (h_x < H_ACT_END) && (v_x < V_ACT_END);
    assign hs_i   = (h_x >= H_SYNC_BEG) && (h_x < H_SYNC_END);
    assign vs_i   = (v_x >= V_SYNC_BEG) && (v_x < V_SYNC_END);
    assign hs_pin = hs_i ~^ SYNC_POL;
    assign vs_pin = vs_i ~^ SYNC_POL;
    assign rgb_m  = active ? bus.rgb_in : 6'b000000;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge
        // counter values; the output byte then describes the same pixel as the colour.
        if (rst) begin
            h  <= '0;
            v  <= '0;
            uo <= UO_RESET;
        end else if (bus.en) begin
            uo <= {hs_pin, rgb_m[0], rgb_m[2], rgb_m[4],
                   vs_pin, rgb_m[1], rgb_m[3], rgb_m[5]};
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Strobes are not gated by en; consumers qualify them.
    assign bus.hpos        = h;
    assign bus.vpos        = v;
    assign bus.active      = active;
    assign bus.line_start  = (h == 10'd0);
    assign bus.frame_start = (h == 10'd0) && (v == 10'd0);
    assign bus.uo_vga      = uo;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator and output register stage that produces the `uo_out` byte of the top-level wrapper in TinyVGA PMOD pin order. It counts pixels and lines for 640x480@60 Hz on a 25 MHz pixel clock, exposes the current beam position to the pixel generator, and registers the returned 6-bit colour together with the delayed syncs. Colour is forced to zero outside the active area.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync polarity. 0 means active-low syncs; 1 means active-high.
- Constraint on both axes: total = ACTIVE+FP+SYNC+BP ≤ 1024.

Ports (name, direction, width, meaning):
- `clk`  in  1  pixel clock. One clock domain; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable. When low, all state holds.
- `rgb_in`  in  6  pixel colour {R[1:0],G[1:0],B[1:0]}. Combinational from the pixel generator for the current `hpos`/`vpos`.
- `hpos`  out  10  current horizontal count (register).
- `vpos`  out  10  current vertical count (register).
- `active`  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE. Combinational from the counters.
- `line_start`  out  1  high when hpos==0.
- `frame_start`  out  1  high when hpos==0 and vpos==0.
- `uo_vga`  out  8  registered PMOD byte. Bit mapping:
  - [7]=hsync, [6]=B0, [5]=G0, [4]=R0
  - [3]=vsync, [2]=B1, [1]=G1, [0]=R1

## Operation

- **Horizontal counter `h`:** counts 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - It increments on each `clk` edge with `en`=1.
  - At HT-1 it wraps to 0.
- **Vertical counter `v`:** counts 0..VT-1 (VT=525).
  - It increments only on the edge where `h` wraps.
  - It wraps to 0 when h==HT-1 and v==VT-1. That edge is the frame wrap.
- **Internal sync terms:**
  - hs_i = (h ≥ H_ACTIVE+H_FP) and (h < H_ACTIVE+H_FP+H_SYNC), i.e. h in 656..751.
  - vs_i = v in V_ACTIVE+V_FP .. +V_SYNC-1, i.e. v in 490..491.
  - Pin level = hs_i XNOR SYNC_POL. With the default polarity, the pin is low while asserted.
- **Output register:** on each edge with `en`=1, `uo_vga` loads:
  - the sync pin levels from the current counters;
  - `rgb_in` ANDed with `active`, mapped to the pin order above.
- **Enable low:**
  - `h`, `v` and `uo_vga` hold.
  - `active`, `line_start` and `frame_start` keep reflecting the held counters. Consumers must qualify the strobes with `en`.
- **Reset (async, on `rst` high):**
  - h=0, v=0.
  - `uo_vga` = syncs deasserted, colour 0. With SYNC_POL=0 this is 8'h88; with SYNC_POL=1 it is 8'h00.
  - After `rst` falls, counting starts on the first edge with `en`=1.
- **Reset mid-line or mid-frame:** immediate return to h=v=0. No partial-line completion.

## Timing

- **Position and colour:** `hpos`/`vpos`/`active` are valid in the cycle the counters hold them. `rgb_in` must settle within that same cycle.
- **Output latency:** `uo_vga` reflects counter state N exactly one enabled edge later.
  - Syncs and colour are delayed identically, so they stay aligned at the pins.
- **Cycle counts after reset release with `en`=1 continuously** (edge k makes h=k mod 800):
  - The first hsync assertion appears on `uo_vga` after edge 657.
  - It lasts 96 cycles.
- **Totals:**
  - Line period 800 cycles.
  - Frame period 420000 cycles.
  - Vsync asserted for 1600 cycles per frame.
- **Strobes:** `line_start` and `frame_start` are single-cycle pulses per line/frame, provided `en` stays high.

## Test plan

- **Reset value:**
  - Stimulus: assert `rst` asynchronously between clock edges.
  - Response: hpos=0, vpos=0 and uo_vga=8'h88 immediately, without waiting for a clock edge. Values hold until `rst` drops.
- **Horizontal timing:**
  - Stimulus: release reset with en=1 and rgb_in=6'h3F.
  - Response: uo_vga[7] goes low after edge 657, returns high after edge 753, and repeats every 800 cycles.
  - Response: colour bits are 1 for output cycles 1..640 and 0 for 641..800.
- **Vertical timing and wrap:**
  - Stimulus: run 420000 cycles.
  - Response: uo_vga[3] is low for lines 490–491 only (1600 cycles).
  - Response: vpos wraps 524→0 with hpos 799→0 on the same edge, and frame_start pulses at that point.
- **Blanking mask:**
  - Stimulus: rgb_in=6'b10_01_11 while at h=639 and then h=640, v=0.
  - Response: the output byte for h=639 has R1=1, R0=0, G1=0, G0=1, B1=1, B0=1. The output byte for h=640 has all colour bits 0.
- **Enable hold:**
  - Stimulus: drop en for 5 cycles at h=100.
  - Response: hpos stays 100, uo_vga is unchanged, and counting resumes at 101 on the next enabled edge.
- **Mid-frame reset:**
  - Stimulus: pulse rst at h=700, v=300.
  - Response: counters go to 0 and uo_vga goes to 8'h88. The next hsync appears after edge 657 counted from the release of `rst`.
